mem_wb_stage_reg: RTL

- Parametrised MEM->WB pipeline stage register: the next generation of the fixed-width MEM/WB register set.
- Adds a valid/ready handshake, stall hold, flush (bubble insertion) and an optional 2-entry skid buffer.
- Supports two memory-data modes: registered, or pass-through with stall capture.
- Selects the writeback value and forms the qualified register-file write enable for the WB stage.

---
 rtl/mem_wb_stage_reg.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage_reg.sv
// mem_wb_stage_reg: MEM->WB pipeline stage register with valid/ready
// handshake, stall hold, flush (bubble insertion), optional 2-entry skid
// buffer, and a choice of registered or pass-through memory read data.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   flush             synchronous kill of every held entry and of any input
//   in_valid/in_ready MEM-side handshake
//   in_wb_en, in_mem_rd, in_dest, in_alu   entry fields from MEM
//   mem_rdata         data-memory read data
//   out_valid/out_ready WB-side handshake
//   out_wb_en, out_mem_rd, out_dest, out_alu, out_mem_data  head entry
//   out_wb_data       selected writeback value (load data or ALU result)
//   rf_we             qualified register-file write enable
//
// MEM_PASS=1 assumes a synchronous memory whose data shows up one cycle
// after accept, and is only meaningful with SKID_EN=0.
module mem_wb_stage_reg #(
   parameter int DATA_WIDTH = 24,
   parameter int DEST_WIDTH = 4,
   parameter int SKID_EN    = 0,
   parameter int MEM_PASS   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_wb_en,
   input  logic                  in_mem_rd,
   input  logic [DEST_WIDTH-1:0] in_dest,
   input  logic [DATA_WIDTH-1:0] in_alu,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_wb_en,
   output logic                  out_mem_rd,
   output logic [DEST_WIDTH-1:0] out_dest,
   output logic [DATA_WIDTH-1:0] out_alu,
   output logic [DATA_WIDTH-1:0] out_mem_data,
   output logic [DATA_WIDTH-1:0] out_wb_data,
   output logic                  rf_we
);

   typedef struct packed {
      logic                  wb_en;
      logic                  mem_rd;
      logic [DEST_WIDTH-1:0] dest;
      logic [DATA_WIDTH-1:0] alu;
      logic [DATA_WIDTH-1:0] mem;
   } entry_t;

   entry_t                in_ent;
   entry_t                head_q, head_d;
   entry_t                skid_q, skid_d;
   logic                  head_vld_q, head_vld_d;
   logic                  skid_vld_q, skid_vld_d;
   logic                  hold_vld_q, hold_vld_d;
   logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
   logic                  accept, emit;

   // In pass-through mode the read data is not known at accept time, so the
   // entry's mem field stays zero and the output comes from mem_rdata/hold.
   assign in_ent = '{wb_en:  in_wb_en,
                     mem_rd: in_mem_rd,
                     dest:   in_dest,
                     alu:    in_alu,
                     mem:    (MEM_PASS != 0) ? '0 : mem_rdata};

   // Skid mode: in_ready depends only on state, breaking the out_ready path.
   assign in_ready  = (SKID_EN != 0) ? !skid_vld_q : (!head_vld_q || out_ready);
   assign out_valid = head_vld_q;

   // Flush overrides both handshakes.
   assign accept = in_valid && in_ready && !flush;
   assign emit   = head_vld_q && out_ready && !flush;

   always_comb begin
      head_d     = head_q;
      skid_d     = skid_q;
      head_vld_d = head_vld_q;
      skid_vld_d = skid_vld_q;
      if (flush) begin
         head_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (emit && skid_vld_q) begin
         // in_ready is low whenever the skid is full, so no accept here
         head_d     = skid_q;
         skid_vld_d = 1'b0;
      end else if (accept && (!head_vld_q || emit)) begin
         head_d     = in_ent;
         head_vld_d = 1'b1;
      end else if (accept) begin
         // only reachable with SKID_EN=1: head stalled, park in skid
         skid_d     = in_ent;
         skid_vld_d = 1'b1;
      end else if (emit) begin
         head_vld_d = 1'b0;
      end
   end

   // Pass-through capture: freeze mem_rdata at the first stalled edge so the
   // load value survives the memory moving on to its next access.
   always_comb begin
      hold_vld_d  = hold_vld_q;
      hold_data_d = hold_data_q;
      if (MEM_PASS != 0) begin
         if (flush || emit) begin
            hold_vld_d = 1'b0;
         end else if (head_vld_q && !out_ready && !hold_vld_q) begin
            hold_vld_d  = 1'b1;
            hold_data_d = mem_rdata;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q      <= '0;
         skid_q      <= '0;
         head_vld_q  <= 1'b0;
         skid_vld_q  <= 1'b0;
         hold_vld_q  <= 1'b0;
         hold_data_q <= '0;
      end else begin
         head_q      <= head_d;
         skid_q      <= skid_d;
         head_vld_q  <= head_vld_d;
         skid_vld_q  <= (SKID_EN != 0) && skid_vld_d;
         hold_vld_q  <= hold_vld_d;
         hold_data_q <= hold_data_d;
      end
   end

   assign out_wb_en    = head_q.wb_en;
   assign out_mem_rd   = head_q.mem_rd;
   assign out_dest     = head_q.dest;
   assign out_alu      = head_q.alu;
   assign out_mem_data = (MEM_PASS != 0) ? (hold_vld_q ? hold_data_q : mem_rdata)
                                         : head_q.mem;
   assign out_wb_data  = head_q.mem_rd ? out_mem_data : head_q.alu;

   // Qualified by out_valid so stale head contents can never write the RF.
   assign rf_we = head_vld_q && head_q.wb_en && out_ready && !flush;

endmodule
